// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: decoder control codes,
// FSM state encoding and the default datapath width.
package div_unit_pkg;

  localparam int DIV_DATA_W = 32;

  // alucontrol codes the decoder uses to raise start/signed_div
  localparam logic [7:0] DIV_CONTROL  = 8'h1A;
  localparam logic [7:0] DIVU_CONTROL = 8'h1B;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_ZERO = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  function automatic logic div_is_div_op(input logic [7:0] alucontrol);
    return (alucontrol == DIV_CONTROL) || (alucontrol == DIVU_CONTROL);
  endfunction

  function automatic logic div_is_signed_op(input logic [7:0] alucontrol);
    return alucontrol == DIV_CONTROL;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between the EX stage (master) and the divider (slave).
interface div_unit_if
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) ();

  logic              start;
  logic              signed_div;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              annul;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;

  modport master (
    output start, signed_div, a, b, annul,
    input  busy, done, hi_out, lo_out
  );

  modport slave (
    input  start, signed_div, a, b, annul,
    output busy, done, hi_out, lo_out
  );

endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle on
// operand magnitudes, with the sign fixup registered as the result enters DONE.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic        clk,
  input  logic        resetn,
  div_unit_if.slave   bus
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] div_q, div_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W:0]   shifted, diff;
  logic              borrow;
  logic [DATA_W-1:0] rem_next, quo_next;

  // Magnitudes wrap naturally: the most negative value stays as its unsigned pattern
  always_comb begin
    a_mag = (bus.signed_div && bus.a[DATA_W-1]) ? -bus.a : bus.a;
    b_mag = (bus.signed_div && bus.b[DATA_W-1]) ? -bus.b : bus.b;
  end

  // Because rem < divisor, the top bit of this DATA_W+1 difference is exactly the borrow
  always_comb begin
    shifted  = {rem_q, quo_q[DATA_W-1]};
    diff     = shifted - {1'b0, div_q};
    borrow   = diff[DATA_W];
    rem_next = borrow ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
    quo_next = {quo_q[DATA_W-2:0], ~borrow};
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      DIV_IDLE: begin
        if (bus.start && !bus.annul) begin
          if (bus.b != '0) begin
            state_d = DIV_BUSY;
            count_d = '0;
            rem_d   = '0;
            quo_d   = a_mag;
            div_d   = b_mag;
            q_neg_d = bus.signed_div & (bus.a[DATA_W-1] ^ bus.b[DATA_W-1]);
            r_neg_d = bus.signed_div & bus.a[DATA_W-1];
          end else begin
            state_d = DIV_ZERO;
            rem_d   = bus.a;
          end
        end
      end

      DIV_BUSY: begin
        if (bus.annul) begin
          state_d = DIV_IDLE;
          count_d = '0;
        end else begin
          rem_d   = rem_next;
          quo_d   = quo_next;
          count_d = count_q + 1'b1;
          if (count_q == LAST_ITER) begin
            state_d = DIV_DONE;
            count_d = '0;
            lo_d    = q_neg_q ? -quo_next : quo_next;
            hi_d    = r_neg_q ? -rem_next : rem_next;
          end
        end
      end

      // Divide by zero yields a defined result instead of trapping
      DIV_ZERO: begin
        if (bus.annul) begin
          state_d = DIV_IDLE;
        end else begin
          state_d = DIV_DONE;
          hi_d    = rem_q;
          lo_d    = '1;
        end
      end

      DIV_DONE: begin
        state_d = DIV_IDLE;
      end

      default: begin
        state_d = DIV_IDLE;
      end
    endcase

    busy_d = (state_d == DIV_BUSY);
    done_d = (state_d == DIV_DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= DIV_IDLE;
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed quotient/remainder vectors,
// latency, divide-by-zero, annul and asynchronous reset behaviour.
module tb_div_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  div_unit_if #(.DATA_W(W)) bus ();

  div_unit #(.DATA_W(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Every comparison in the bench funnels through here
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Holds start for exactly one rising edge (E0) and returns 1 time unit after it
  task automatic applyStimulus(input logic sd, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.signed_div = sd;
    bus.a          = av;
    bus.b          = bv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // lat counts rising edges from E0 up to the one after which done is seen
  task automatic waitDone(output int lat, output logic busy_seen, output logic busy_at_done);
    lat       = 1;
    busy_seen = bus.busy;
    while (!bus.done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (!bus.done && bus.busy) busy_seen = 1'b1;
    end
    busy_at_done = bus.busy;
  endtask

  task automatic runDivide(input string tag, input logic sd, input logic [31:0] av,
                           input logic [31:0] bv, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi, input int exp_lat,
                           input logic exp_busy);
    int   lat;
    logic busy_seen, busy_at_done;
    applyStimulus(sd, av, bv);
    waitDone(lat, busy_seen, busy_at_done);
    checkOutput({tag, " done"}, 32'(bus.done), 32'd1);
    checkOutput({tag, " latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, " busy_in_done"}, 32'(busy_at_done), 32'd0);
    checkOutput({tag, " busy_seen"}, 32'(busy_seen), 32'(exp_busy));
    checkOutput({tag, " lo"}, bus.lo_out, exp_lo);
    checkOutput({tag, " hi"}, bus.hi_out, exp_hi);
    @(posedge clk);
    #1;
    checkOutput({tag, " done_pulse_end"}, 32'(bus.done), 32'd0);
    checkOutput({tag, " lo_hold"}, bus.lo_out, exp_lo);
  endtask

  initial begin
    int   lat;
    logic busy_seen, busy_at_done, done_seen;

    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.annul      = 1'b0;
    resetn         = 1'b0;
    #12;
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset hi", bus.hi_out, 32'd0);
    checkOutput("reset lo", bus.lo_out, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // start together with annul must leave the divider idle
    @(negedge clk);
    bus.start = 1'b1;
    bus.annul = 1'b1;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.annul = 1'b0;
    checkOutput("start+annul busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("start+annul done", 32'(bus.done), 32'd0);
    checkOutput("start+annul busy2", 32'(bus.busy), 32'd0);

    runDivide("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b1);
    runDivide("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1'b1);
    runDivide("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, 1'b1);
    runDivide("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, 1'b1);
    runDivide("divu min/max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33, 1'b1);
    runDivide("divu 5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 2, 1'b0);

    // annul partway through a divide: no done pulse, previous result kept
    applyStimulus(1'b0, 32'd100, 32'd7);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    bus.annul = 1'b1;
    @(posedge clk);
    #1;
    bus.annul = 1'b0;
    checkOutput("annul busy", 32'(bus.busy), 32'd0);
    checkOutput("annul done", 32'(bus.done), 32'd0);
    done_seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) done_seen = 1'b1;
    end
    checkOutput("annul no_done", 32'(done_seen), 32'd0);
    checkOutput("annul hi_kept", bus.hi_out, 32'd5);
    checkOutput("annul lo_kept", bus.lo_out, 32'hFFFF_FFFF);
    runDivide("divu 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, 1'b1);

    // a second start while busy is dropped
    applyStimulus(1'b0, 32'd100, 32'd7);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'd50;
    bus.b     = 32'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    waitDone(lat, busy_seen, busy_at_done);
    checkOutput("ignore_start done", 32'(bus.done), 32'd1);
    checkOutput("ignore_start lo", bus.lo_out, 32'd14);
    checkOutput("ignore_start hi", bus.hi_out, 32'd2);
    @(posedge clk);
    #1;

    // asynchronous reset mid-divide clears outputs without a clock edge
    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2);
    repeat (19) @(posedge clk);
    #2;
    checkOutput("pre_reset busy", 32'(bus.busy), 32'd1);
    resetn = 1'b0;
    #1;
    checkOutput("async_reset busy", 32'(bus.busy), 32'd0);
    checkOutput("async_reset done", 32'(bus.done), 32'd0);
    checkOutput("async_reset hi", bus.hi_out, 32'd0);
    checkOutput("async_reset lo", bus.lo_out, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_reset busy", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
